// File: rtl/four_bit_dff_down_counter_pkg.sv
// Shared definitions for the borrow-chain down counter: default width,
// count vector type and the value every stage takes on clear.
package four_bit_dff_down_counter_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef logic [WIDTH_DEFAULT-1:0] count_t;

  localparam count_t CLEAR_VALUE = {WIDTH_DEFAULT{1'b0}};

endpackage : four_bit_dff_down_counter_pkg

// File: rtl/four_bit_dff_down_counter_if.sv
// Count bus between the counter (master, drives the value) and its
// consumers (slave, observes the value).
interface four_bit_dff_down_counter_if
  import four_bit_dff_down_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [WIDTH-1:0] count;

  modport master (output count);
  modport slave  (input  count);

endinterface : four_bit_dff_down_counter_if

// File: rtl/four_bit_dff_down_counter_down_count_stage.sv
// One D-flop toggle cell of the down counter. The cell toggles when a borrow
// arrives from below and passes a borrow upward only while it is itself 0,
// so the stage above toggles exactly when every lower stage is 0.
module down_count_stage
  import four_bit_dff_down_counter_pkg::*;
(
  input  logic Clk,
  input  logic ClrN,
  input  logic borrow_in,
  output logic q,
  output logic borrow_out
);

  logic q_r;

  // Stage flop: clear wins, otherwise toggle on an incoming borrow.
  always_ff @(posedge Clk) begin
    if (!ClrN) begin
      q_r <= CLEAR_VALUE[0];
    end else begin
      q_r <= q_r ^ borrow_in;
    end
  end

  assign q          = q_r;
  assign borrow_out = borrow_in & ~q_r;

endmodule : down_count_stage

// File: rtl/four_bit_dff_down_counter.sv
// Free-running WIDTH-bit binary down counter. Every stage is clocked by Clk;
// the borrow chain decides which stages toggle, so all bits change on the
// same edge. The count leaves directly from the stage flops.
module four_bit_dff_down_counter
  import four_bit_dff_down_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
)(
  input  logic                               Clk,
  input  logic                               ClrN,
  four_bit_dff_down_counter_if.master        bus
);

  logic [WIDTH:0]   borrow_s;
  logic [WIDTH-1:0] count_s;
  logic             borrow_unused_s;

  // The lowest stage always receives a borrow: it toggles every edge.
  assign borrow_s[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage
      down_count_stage u_stage (
        .Clk        (Clk),
        .ClrN       (ClrN),
        .borrow_in  (borrow_s[i]),
        .q          (count_s[i]),
        .borrow_out (borrow_s[i+1])
      );
    end
  endgenerate

  // The borrow out of the top stage marks wrap-around; no flag is exported.
  assign borrow_unused_s = borrow_s[WIDTH];

  assign bus.count = count_s;

endmodule : four_bit_dff_down_counter

// File: tb/tb_four_bit_dff_down_counter.sv
// Directed self-checking bench for the 4-bit borrow-chain down counter.
module tb_four_bit_dff_down_counter;

  logic       Clk;
  logic       ClrN;
  logic [3:0] ref_cnt;
  logic [15:0] seen;
  int         checks;
  int         failures;

  four_bit_dff_down_counter_if #(.WIDTH(4)) bus ();

  four_bit_dff_down_counter #(.WIDTH(4)) dut (
    .Clk  (Clk),
    .ClrN (ClrN),
    .bus  (bus)
  );

  // 40 ns clock, first rising edge at 20 ns.
  initial Clk = 1'b0;
  always #20 Clk = ~Clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    seen     = 16'h0000;
    ClrN     = 1'b0;

    // Clear held low: 0000 after edge at 20 ns and still at 40 ns.
    #30;
    check("reset_30ns", bus.count, 4'b0000);
    #10;
    check("reset_40ns", bus.count, 4'b0000);
    #5;
    ClrN = 1'b1;

    // First edges after release: F, E, D, C.
    @(negedge Clk); check("release_e1", bus.count, 4'b1111);
    @(negedge Clk); check("release_e2", bus.count, 4'b1110);
    @(negedge Clk); check("release_e3", bus.count, 4'b1101);
    @(negedge Clk); check("release_e4", bus.count, 4'b1100);

    // Clear back to 0000, then 16 edges plus one for the wrap.
    ClrN = 1'b0;
    @(negedge Clk); check("clear_again", bus.count, 4'b0000);
    ClrN    = 1'b1;
    ref_cnt = 4'b0000;
    for (int k = 0; k < 17; k++) begin
      @(negedge Clk);
      ref_cnt = ref_cnt - 4'd1;
      check("wrap_seq", bus.count, ref_cnt);
      if (k < 16) seen[bus.count] = 1'b1;
    end
    checks++;
    assert (seen === 16'hFFFF) else begin
      failures++;
      $error("FAIL wrap_coverage observed=%h expected=%h", seen, 16'hFFFF);
    end

    // Walk down to 1010, then clear mid-count.
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      ref_cnt = ref_cnt - 4'd1;
      check("walk_to_a", bus.count, ref_cnt);
    end
    check("at_1010", bus.count, 4'b1010);
    ClrN = 1'b0;
    @(negedge Clk); check("midcount_clear", bus.count, 4'b0000);
    ClrN = 1'b1;
    @(negedge Clk); check("resume_after_clear", bus.count, 4'b1111);

    // Short clear pulse between negedge and next rising edge: ignored.
    #5  ClrN = 1'b0;
    #10 ClrN = 1'b1;
    @(negedge Clk); check("glitch_before_edge", bus.count, 4'b1110);

    // Short clear pulse just after a rising edge: ignored.
    @(posedge Clk);
    #5  ClrN = 1'b0;
    #10 ClrN = 1'b1;
    @(negedge Clk); check("glitch_after_edge", bus.count, 4'b1101);

    // Long run: every bit settled 1 ns after the edge and stable to the negedge.
    ref_cnt = 4'b1101;
    for (int k = 0; k < 30; k++) begin
      @(posedge Clk);
      ref_cnt = ref_cnt - 4'd1;
      #1;
      check("long_post_edge", bus.count, ref_cnt);
      @(negedge Clk);
      check("long_mid_cycle", bus.count, ref_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_four_bit_dff_down_counter
